// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
//   UART_DATA_W  : width of one received byte
//   FIFO_ENTRY_W : stored entry, {err flag, data byte}
//   ERR_CNT_W    : width of the saturating error counter
//   clog2()      : ceiling log2, used to size pointers and the occupancy count
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int FIFO_ENTRY_W = UART_DATA_W + 1;
  localparam int ERR_CNT_W    = 8;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: DEPTH x FIFO_ENTRY_W.
// One write port, one read port with a 1-cycle registered output.
// Ports:
//   clk, rst        : clock; rst clears only the read output register
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr  : read request; rd_data updates on the following edge
//   rd_data         : registered read data, holds between reads
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [FIFO_ENTRY_W-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [FIFO_ENTRY_W-1:0] rd_data
);

  logic [FIFO_ENTRY_W-1:0] mem_q [DEPTH];

  // No reset on the array itself; contents are discarded by pointer reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // On a full FIFO a simultaneous read and write hit the same address;
  // the read returns the old (oldest) entry, which is what we want.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver.
// Captures {rx_err, rx_data} on every rx_valid strobe into a FIFO, which the
// consumer drains with rd_en (1-cycle read latency, no fall-through).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rx_data/rx_valid/rx_err : byte strobe from the receiver (cannot stall)
//   rd_en                 : pop request
//   rd_data/rd_err/rd_valid : popped entry, rd_valid is a one-cycle strobe
//   empty/full/almost_full/count : occupancy status (registered)
//   overrun, clr_ovr      : sticky drop flag and its clear
//   err_cnt               : saturating count of accepted bytes with rx_err=1
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_err,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_err,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]        count_nxt;
  logic [FIFO_ENTRY_W-1:0] mem_rd;
  logic                    rd_acc;
  logic                    wr_acc;

  // A read on a full FIFO frees a slot, so the write in that cycle survives.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = rx_valid & (~full | rd_acc);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data ({rx_err, rx_data}),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  assign rd_data = mem_rd[UART_DATA_W-1:0];
  assign rd_err  = mem_rd[UART_DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      rd_valid    <= 1'b0;
      overrun     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      count       <= count_nxt;
      // Flags decode the next count so they line up with count itself.
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == DEPTH_C);
      almost_full <= (count_nxt >= AF_C);
      rd_valid    <= rd_acc;
      // Setting wins over a same-cycle clear so no drop goes unreported.
      if (rx_valid && full && !rd_acc) overrun <= 1'b1;
      else if (clr_ovr)                overrun <= 1'b0;
      if (wr_acc && rx_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
